// File: rtl/rm_index_gen_pkg.sv
// Shared types and default sizing for the random-modulo set index generator.
// The optional randomized placement is enabled by defining RANDOM_MODULO_EN.
package rm_index_gen_pkg;

    localparam int unsigned RM_NUM_THREADS   = 4;
    localparam int unsigned RM_SET_IDX_WIDTH = 6;
    localparam int unsigned RM_TAG_WIDTH     = 20;
    localparam int unsigned RM_RAND_WIDTH    = 16;
    localparam int unsigned RM_THREAD_W      = $clog2(RM_NUM_THREADS);

    // Hardware thread index, shared with the rest of the L1 pipeline.
    typedef logic [RM_THREAD_W-1:0] rm_thread_t;

    // Placement seed; same width as the PRNG output it is sampled from.
    typedef logic [RM_RAND_WIDTH-1:0] rm_seed_t;

    // Reseed sequencing: wait for the cache flush before changing placement.
    typedef enum logic [1:0] {
        RM_IDLE  = 2'd0,
        RM_FLUSH = 2'd1,
        RM_LATCH = 2'd2
    } rm_state_t;

endpackage

// File: rtl/rm_permute.sv
// Combinational random-modulo permutation of a set index.
// idx_set = rotate_left(set_raw ^ mix[R +: W], mix[R-1:0] % W), R = clog2(W).
// For a fixed mix this is a bijection on set_raw. Used by rm_index_gen when
// RANDOM_MODULO_EN is defined; tag-check paths can reuse it to recompute an index.
module rm_permute #(
    parameter int unsigned SET_IDX_WIDTH = 6,
    parameter int unsigned RAND_WIDTH    = 16
) (
    input  logic [SET_IDX_WIDTH-1:0] set_raw,
    input  logic [RAND_WIDTH-1:0]    mix,
    output logic [SET_IDX_WIDTH-1:0] idx_set
);

    localparam int unsigned R = $clog2(SET_IDX_WIDTH);
    // One extra bit so that a power-of-two width does not become a modulus of zero.
    localparam logic [R:0] SET_W_C = SET_IDX_WIDTH[R:0];

    logic [R:0]                 rot_wide_s;
    logic [R-1:0]               rot_s;
    logic [SET_IDX_WIDTH-1:0]   xmask_s;
    logic [SET_IDX_WIDTH-1:0]   pre_s;
    logic [2*SET_IDX_WIDTH-1:0] dbl_s;
    logic                       unused_s;

    // Derive rotation and xor mask from the mix, then rotate via a doubled vector.
    always_comb begin
        rot_wide_s = {1'b0, mix[R-1:0]} % SET_W_C;
        rot_s      = rot_wide_s[R-1:0];
        xmask_s    = mix[R +: SET_IDX_WIDTH];
        pre_s      = set_raw ^ xmask_s;
        dbl_s      = {pre_s, pre_s} << rot_s;
        idx_set    = dbl_s[2*SET_IDX_WIDTH-1 -: SET_IDX_WIDTH];
    end

    // Upper mix bits and the low half of the doubled vector are intentionally dropped.
    assign unused_s = ^{rot_wide_s, mix, dbl_s};

endmodule

// File: rtl/rm_index_gen.sv
// Random-modulo set index generator: per-thread placement seeds, reseed
// sequencing through a cache flush handshake, and a registered index mapping.
// Macro RANDOM_MODULO_EN: defined -> seeded permutation with flush-guarded reseed;
// undefined -> idx_set = lookup_set (registered), reseed completes immediately.
module rm_index_gen
    import rm_index_gen_pkg::*;
#(
    parameter int unsigned NUM_THREADS   = RM_NUM_THREADS,
    parameter int unsigned SET_IDX_WIDTH = RM_SET_IDX_WIDTH,
    parameter int unsigned TAG_WIDTH     = RM_TAG_WIDTH,
    parameter int unsigned RAND_WIDTH    = RM_RAND_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [RAND_WIDTH-1:0]          rand_i,
    input  logic                           reseed_req_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] reseed_req_thread,
    output logic                           reseed_req_ready,
    output logic                           flush_req,
    input  logic                           flush_ack,
    input  logic                           lookup_valid,
    input  logic [$clog2(NUM_THREADS)-1:0] lookup_thread,
    input  logic [TAG_WIDTH-1:0]           lookup_tag,
    input  logic [SET_IDX_WIDTH-1:0]       lookup_set,
    output logic                           lookup_stall,
    output logic                           idx_valid,
    output logic [SET_IDX_WIDTH-1:0]       idx_set
);

    localparam int unsigned THREAD_W = $clog2(NUM_THREADS);

    logic                     lookup_ok_s;
    logic [SET_IDX_WIDTH-1:0] idx_next_s;
    logic                     idx_valid_r;
    logic [SET_IDX_WIDTH-1:0] idx_set_r;

`ifdef RANDOM_MODULO_EN
    rm_state_t                state_r;
    rm_state_t                state_s;
    logic [THREAD_W-1:0]      tgt_thread_r;
    logic [RAND_WIDTH-1:0]    seed_r [NUM_THREADS];
    logic [RAND_WIDTH-1:0]    mix_s;
    logic                     flush_req_r;
    logic                     hs_s;
    logic                     unused_s;

    assign reseed_req_ready = (state_r == RM_IDLE);
    assign lookup_stall     = (state_r != RM_IDLE);
    assign flush_req        = flush_req_r;
    assign hs_s             = reseed_req_valid & reseed_req_ready;
    assign lookup_ok_s      = lookup_valid & (state_r == RM_IDLE);
    assign mix_s            = lookup_tag[RAND_WIDTH-1:0] ^ seed_r[lookup_thread];
    // Tag bits above the seed width do not take part in the mix.
    assign unused_s         = ^lookup_tag;

    rm_permute #(
        .SET_IDX_WIDTH (SET_IDX_WIDTH),
        .RAND_WIDTH    (RAND_WIDTH)
    ) u_permute (
        .set_raw (lookup_set),
        .mix     (mix_s),
        .idx_set (idx_next_s)
    );

    // Reseed sequencer next state: flush must complete before the seed changes.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RM_IDLE: begin
                if (hs_s) begin
                    state_s = RM_FLUSH;
                end else begin
                    state_s = RM_IDLE;
                end
            end
            RM_FLUSH: begin
                if (flush_ack) begin
                    state_s = RM_LATCH;
                end else begin
                    state_s = RM_FLUSH;
                end
            end
            RM_LATCH: state_s = RM_IDLE;
            default:  state_s = RM_IDLE;
        endcase
    end

    // State, flush request and latched target thread registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= RM_IDLE;
            flush_req_r  <= 1'b0;
            tgt_thread_r <= {THREAD_W{1'b0}};
        end else begin
            state_r     <= state_s;
            flush_req_r <= (state_s == RM_FLUSH);
            if (hs_s) begin
                tgt_thread_r <= reseed_req_thread;
            end
        end
    end

    // Seed bank: the target thread samples the PRNG once the flush is done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NUM_THREADS); i++) begin
                seed_r[i] <= {RAND_WIDTH{1'b0}};
            end
        end else if (state_r == RM_LATCH) begin
            seed_r[tgt_thread_r] <= rand_i;
        end
    end
`else
    logic unused_s;

    assign reseed_req_ready = 1'b1;
    assign flush_req        = 1'b0;
    assign lookup_stall     = 1'b0;
    assign lookup_ok_s      = lookup_valid;
    assign idx_next_s       = lookup_set;
    // Placement is fixed, so the PRNG, flush and thread/tag inputs have no effect.
    assign unused_s = ^{rand_i, flush_ack, reseed_req_valid, reseed_req_thread,
                        lookup_thread, lookup_tag};
`endif

    // Registered lookup result; the index holds when no lookup is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_valid_r <= 1'b0;
            idx_set_r   <= {SET_IDX_WIDTH{1'b0}};
        end else begin
            idx_valid_r <= lookup_ok_s;
            if (lookup_ok_s) begin
                idx_set_r <= idx_next_s;
            end
        end
    end

    assign idx_valid = idx_valid_r;
    assign idx_set   = idx_set_r;

endmodule

// File: tb/tb_rm_index_gen.sv
// Self-checking bench for rm_index_gen (default sizing). Covers both builds
// selected by RANDOM_MODULO_EN.
module tb_rm_index_gen;

    logic        clk;
    logic        reset;
    logic [15:0] rand_i;
    logic        reseed_req_valid;
    logic [1:0]  reseed_req_thread;
    logic        reseed_req_ready;
    logic        flush_req;
    logic        flush_ack;
    logic        lookup_valid;
    logic [1:0]  lookup_thread;
    logic [19:0] lookup_tag;
    logic [5:0]  lookup_set;
    logic        lookup_stall;
    logic        idx_valid;
    logic [5:0]  idx_set;

    rm_index_gen dut (
        .clk               (clk),
        .reset             (reset),
        .rand_i            (rand_i),
        .reseed_req_valid  (reseed_req_valid),
        .reseed_req_thread (reseed_req_thread),
        .reseed_req_ready  (reseed_req_ready),
        .flush_req         (flush_req),
        .flush_ack         (flush_ack),
        .lookup_valid      (lookup_valid),
        .lookup_thread     (lookup_thread),
        .lookup_tag        (lookup_tag),
        .lookup_set        (lookup_set),
        .lookup_stall      (lookup_stall),
        .idx_valid         (idx_valid),
        .idx_set           (idx_set)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] s;
    } exp_t;

    typedef struct {
        logic [1:0]  th;
        logic [19:0] tag;
        logic [5:0]  set;
        logic [5:0]  exp;
    } vec_t;

    exp_t        sb_q[$];
    vec_t        tab[6];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_seed [4];
    logic        m_idle;
    logic [5:0]  m_last;

    function automatic logic [5:0] model_map(logic [19:0] tag, logic [15:0] seed, logic [5:0] set);
`ifdef RANDOM_MODULO_EN
        logic [15:0] m;
        logic [5:0]  x;
        int          r;
        m = tag[15:0] ^ seed;
        r = int'(m[2:0]) % 6;
        x = set ^ m[8:3];
        for (int i = 0; i < r; i++) x = {x[4:0], x[5]};
        return x;
`else
        logic unused_b;
        unused_b = ^{tag, seed};
        return set;
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Drive one lookup and push what the DUT must show after the next edge.
    task automatic look(logic v, logic [1:0] th, logic [19:0] tag, logic [5:0] set);
        exp_t e;
        lookup_valid  = v;
        lookup_thread = th;
        lookup_tag    = tag;
        lookup_set    = set;
        e.v = v && m_idle;
        if (e.v) m_last = model_map(tag, m_seed[th], set);
        e.s = m_last;
        sb_q.push_back(e);
    endtask

    // Clock once and compare the registered result with the scoreboard head.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        rand_i = 16'($urandom);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty actual=0 required=1");
        end else begin
            e = sb_q.pop_front();
            chk("idx_valid", 32'(idx_valid), 32'(e.v));
            chk("idx_set", 32'(idx_set), 32'(e.s));
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        for (int i = 0; i < 4; i++) m_seed[i] = 16'h0000;
        m_last = 6'h00;
        m_idle = 1'b1;
    endtask

`ifdef RANDOM_MODULO_EN
    // Full reseed: handshake (optional same-cycle lookup), FLUSH for ack_wait+1 cycles, LATCH.
    task automatic reseed(logic [1:0] th, logic [15:0] rv, int ack_wait,
                          logic lk, logic [19:0] ltag, logic [5:0] lset);
        int hi;
        chk("ready_idle", 32'(reseed_req_ready), 32'd1);
        reseed_req_valid  = 1'b1;
        reseed_req_thread = th;
        look(lk, th, ltag, lset);
        tick();
        m_idle = 1'b0;
        chk("stall_flush", 32'(lookup_stall), 32'd1);
        // requester of another thread keeps asking; must not be accepted
        reseed_req_thread = th ^ 2'd1;
        hi = 0;
        for (int k = 0; k <= ack_wait; k++) begin
            if (flush_req === 1'b1) hi++;
            chk("ready_busy", 32'(reseed_req_ready), 32'd0);
            flush_ack = (k == ack_wait);
            look(1'b1, th, 20'(k), 6'(k));
            tick();
        end
        flush_ack        = 1'b0;
        reseed_req_valid = 1'b0;
        chk("flush_len", 32'(hi), 32'(ack_wait + 1));
        chk("flush_drop", 32'(flush_req), 32'd0);
        chk("stall_latch", 32'(lookup_stall), 32'd1);
        rand_i = rv;
        look(1'b1, th, 20'h00000, 6'h00);
        tick();
        m_seed[th] = rv;
        m_idle     = 1'b1;
        chk("ready_back", 32'(reseed_req_ready), 32'd1);
        chk("stall_back", 32'(lookup_stall), 32'd0);
    endtask
`else
    task automatic reseed_off(logic [1:0] th);
        chk("ready_off", 32'(reseed_req_ready), 32'd1);
        reseed_req_valid  = 1'b1;
        reseed_req_thread = th;
        flush_ack         = 1'b1;
        look(1'b1, th, 20'h12345, 6'h2A);
        tick();
        reseed_req_valid = 1'b0;
        flush_ack        = 1'b0;
        chk("flush_off", 32'(flush_req), 32'd0);
        chk("stall_off", 32'(lookup_stall), 32'd0);
        chk("ready_off2", 32'(reseed_req_ready), 32'd1);
        look(1'b1, th, 20'h00000, 6'h11);
        tick();
        chk("flush_off2", 32'(flush_req), 32'd0);
    endtask
`endif

    initial begin
        logic [63:0] seen;
        reset             = 1'b0;
        rand_i            = 16'h0000;
        reseed_req_valid  = 1'b0;
        reseed_req_thread = 2'd0;
        flush_ack         = 1'b0;
        lookup_valid      = 1'b0;
        lookup_thread     = 2'd0;
        lookup_tag        = 20'h00000;
        lookup_set        = 6'h00;
        model_reset();

        // seed = 0 for all threads after reset
        tab[0] = '{2'd0, 20'h00003, 6'h05, 6'h28};
        tab[1] = '{2'd0, 20'h00000, 6'h2A, 6'h2A};
        tab[2] = '{2'd2, 20'h00008, 6'h00, 6'h01};
        tab[3] = '{2'd3, 20'h00006, 6'h01, 6'h01};
        tab[4] = '{2'd1, 20'h00007, 6'h01, 6'h02};
        tab[5] = '{2'd0, 20'hF01FD, 6'h15, 6'h15};
`ifndef RANDOM_MODULO_EN
        for (int i = 0; i < 6; i++) tab[i].exp = tab[i].set;
`endif

        #12;
        chk("rst_idx_valid", 32'(idx_valid), 32'd0);
        chk("rst_idx_set", 32'(idx_set), 32'd0);
        chk("rst_flush_req", 32'(flush_req), 32'd0);
        chk("rst_stall", 32'(lookup_stall), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ready", 32'(reseed_req_ready), 32'd1);

        // table-driven lookups
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            lookup_valid  = 1'b1;
            lookup_thread = tab[i].th;
            lookup_tag    = tab[i].tag;
            lookup_set    = tab[i].set;
            e.v = 1'b1;
            e.s = tab[i].exp;
            m_last = tab[i].exp;
            sb_q.push_back(e);
            tick();
        end
        // idle cycle: index must hold
        look(1'b0, 2'd0, 20'h00000, 6'h00);
        tick();

`ifdef RANDOM_MODULO_EN
        // flush_ack outside FLUSH is ignored
        flush_ack = 1'b1;
        look(1'b0, 2'd0, 20'h00000, 6'h00);
        tick();
        flush_ack = 1'b0;
        chk("ack_idle_flush", 32'(flush_req), 32'd0);
        chk("ack_idle_ready", 32'(reseed_req_ready), 32'd1);

        reseed(2'd1, 16'h00FF, 5, 1'b0, 20'h00000, 6'h00);
        // first cycle after LATCH uses new seed
        begin
            exp_t e;
            lookup_valid  = 1'b1;
            lookup_thread = 2'd1;
            lookup_tag    = 20'h00000;
            lookup_set    = 6'h00;
            e.v = 1'b1;
            e.s = 6'h3E;
            m_last = 6'h3E;
            sb_q.push_back(e);
            tick();
        end
        // thread 0 request held during FLUSH was not accepted
        look(1'b1, 2'd0, 20'h00003, 6'h05);
        tick();
        chk("no_spurious_flush", 32'(flush_req), 32'd0);

        // lookup in the handshake cycle is served with the old seed
        reseed(2'd1, 16'hBEEF, 2, 1'b1, 20'h00000, 6'h00);
        look(1'b1, 2'd1, 20'h0A5A5, 6'h3C);
        tick();

        // bijectivity sweep with seed 0x1234
        reseed(2'd0, 16'h1234, 0, 1'b0, 20'h00000, 6'h00);
        seen = 64'd0;
        for (int s = 0; s < 64; s++) begin
            look(1'b1, 2'd0, 20'h0ABCD, 6'(s));
            tick();
            if (idx_valid === 1'b1) seen[idx_set] = 1'b1;
        end
        chk("distinct", 32'($countones(seen)), 32'd64);

        // reset in the middle of FLUSH
        reseed_req_valid  = 1'b1;
        reseed_req_thread = 2'd1;
        look(1'b0, 2'd0, 20'h00000, 6'h00);
        tick();
        reseed_req_valid = 1'b0;
        m_idle = 1'b0;
        look(1'b0, 2'd0, 20'h00000, 6'h00);
        tick();
        chk("pre_rst_flush", 32'(flush_req), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_flush", 32'(flush_req), 32'd0);
        chk("rst_mid_stall", 32'(lookup_stall), 32'd0);
        chk("rst_mid_idx_valid", 32'(idx_valid), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_mid_ready", 32'(reseed_req_ready), 32'd1);
        look(1'b1, 2'd1, 20'h00000, 6'h00);
        tick();
        look(1'b1, 2'd0, 20'h00003, 6'h05);
        tick();
        chk("post_rst_flush", 32'(flush_req), 32'd0);
`else
        reseed_off(2'd1);
        reseed_off(2'd3);
        look(1'b1, 2'd2, 20'hFFFFF, 6'h2A);
        tick();
        // reset mid-stream clears the registered result
        look(1'b1, 2'd0, 20'h00000, 6'h3F);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_idx_valid", 32'(idx_valid), 32'd0);
        chk("rst_mid_idx_set", 32'(idx_set), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        look(1'b1, 2'd1, 20'h00003, 6'h05);
        tick();
`endif

        look(1'b0, 2'd0, 20'h00000, 6'h00);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
